// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and default byte width.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACT  = 3'd2,
        ST_WAIT_CPLT = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester at or after last_grant+1 (mod N_REQ).
module rr_picker #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest offset to the nearest so the nearest hit is the last write.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = N_REQ; off >= 1; off--) begin
            cand     = (32'(last_grant) + off) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional watchdog on the transmitter handshake: define UART_TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_BITS      = UART_DATA_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_BITS-1:0] req_byte,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic                       busy,
    output logic [DATA_BITS-1:0]       tx_byte,
    output logic                       tx_en,
    input  logic                       tx_active,
    input  logic                       tx_cplt
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 timeout;

    rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req        (req),
        .last_grant (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

`ifdef UART_TX_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    // Counts across both wait states; any other state clears it.
    always_comb begin
        wd_d = '0;
        if (state_q == ST_WAIT_ACT || state_q == ST_WAIT_CPLT) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout = (state_q == ST_WAIT_ACT || state_q == ST_WAIT_CPLT) &&
                     (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(N_REQ - 1);
            win_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        byte_d  = byte_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ISSUE;
                    last_d  = pick_idx;
                    win_d   = pick_idx;
                    byte_d  = req_byte[32'(pick_idx) * DATA_BITS +: DATA_BITS];
                end
            end
            ST_ISSUE:     state_d = ST_WAIT_ACT;
            ST_WAIT_ACT: begin
                if (timeout)        state_d = ST_GAP;
                else if (tx_active) state_d = ST_WAIT_CPLT;
            end
            ST_WAIT_CPLT: begin
                if (timeout || tx_cplt) state_d = ST_GAP;
            end
            ST_GAP:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt     = '0;
        done    = '0;
        err     = timeout;
        busy    = (state_q != ST_IDLE);
        tx_en   = (state_q == ST_ISSUE);
        tx_byte = byte_q;
        if (state_q == ST_IDLE && pick_valid && !rst) begin
            gnt[pick_idx] = 1'b1;
        end
        if (state_q == ST_WAIT_CPLT && tx_cplt && !timeout) begin
            done[win_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural 10-clk/bit UART transmitter.
module tb_uart_tx_arbiter;

    localparam int unsigned N         = 4;
    localparam int unsigned DW        = 8;
    localparam int unsigned LOG_DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_byte;
    logic [N-1:0]  gnt, done;
    logic          err, busy, tx_en, tx_active, tx_cplt;
    logic [DW-1:0] tx_byte;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .DATA_BITS      (DW),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_byte  (req_byte),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .tx_byte   (tx_byte),
        .tx_en     (tx_en),
        .tx_active (tx_active),
        .tx_cplt   (tx_cplt)
    );

    always #5 clk = ~clk;

    // Behavioural transmitter: start, 8 data LSB-first, stop; 10 clocks per bit.
    logic       m_active, m_cplt, inject_cplt, force_idle, txd;
    logic [9:0] m_frame;
    int unsigned m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_cplt   <= 1'b0;
            m_cnt    <= 0;
            m_frame  <= '1;
        end else begin
            m_cplt <= 1'b0;
            if (m_active) begin
                if (m_cnt == 99) begin
                    m_active <= 1'b0;
                    m_cplt   <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (tx_en && !force_idle) begin
                m_active <= 1'b1;
                m_cnt    <= 0;
                m_frame  <= {1'b1, tx_byte, 1'b0};
            end
        end
    end

    assign tx_active = m_active;
    assign tx_cplt   = m_cplt | inject_cplt;
    assign txd       = m_active ? m_frame[m_cnt / 10] : 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int bad_onehot = 0;
    int gnt_done_same = 0;
    logic auto_drop = 1'b1;
    logic last_busy;
    logic [N+N+3+DW-1:0] last_out;

    int gnt_idx_q[$], gnt_cyc_q[$], done_idx_q[$], done_cyc_q[$], ten_cyc_q[$], err_cyc_q[$];
    logic [DW-1:0] ten_byte_q[$];
    logic line_log [LOG_DEPTH];
    logic [DW-1:0] exp_byte [N] = '{8'hC3, 8'h5A, 8'hA5, 8'h3C};

    function automatic int onehot_idx(input logic [N-1:0] v);
        int idx = -1;
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = i;
                cnt++;
            end
        end
        return (cnt == 1) ? idx : -1;
    endfunction

    task automatic clear_logs();
        gnt_idx_q.delete();
        gnt_cyc_q.delete();
        done_idx_q.delete();
        done_cyc_q.delete();
        ten_cyc_q.delete();
        err_cyc_q.delete();
        ten_byte_q.delete();
    endtask

    task automatic step();
        logic [N-1:0] g;
        int idx;
        @(negedge clk);
        if (gnt !== '0) begin
            idx = onehot_idx(gnt);
            if (idx < 0) bad_onehot++;
            gnt_idx_q.push_back(idx);
            gnt_cyc_q.push_back(cyc);
        end
        if (done !== '0) begin
            idx = onehot_idx(done);
            if (idx < 0) bad_onehot++;
            done_idx_q.push_back(idx);
            done_cyc_q.push_back(cyc);
        end
        if (gnt !== '0 && done !== '0) gnt_done_same++;
        if (tx_en === 1'b1) begin
            ten_cyc_q.push_back(cyc);
            ten_byte_q.push_back(tx_byte);
        end
        if (err === 1'b1) err_cyc_q.push_back(cyc);
        if (cyc < LOG_DEPTH) line_log[cyc] = txd;
        last_busy = busy;
        last_out  = {gnt, done, err, busy, tx_en, tx_byte};
        g = gnt;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_drop) req = req & ~g;
    endtask

    task automatic wait_gnts(input int n, input int budget, input string name);
        int k = 0;
        while (gnt_idx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (gnt_idx_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s: gnt count=%0d required=%0d within %0d cycles", name, gnt_idx_q.size(), n, budget);
        end
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int k = 0;
        while (done_idx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (done_idx_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL %s: done count=%0d required=%0d within %0d cycles", name, done_idx_q.size(), n, budget);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = '0;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (last_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got=%h required=0", last_out);
        end
        rst = 1'b0;
        step();
        checks++;
        if (last_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got=%b required=0", last_busy);
        end
    endtask

    task automatic test_single();
        logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int t;
        clear_logs();
        inject_cplt = 1'b1;
        step();
        inject_cplt = 1'b0;
        req = 4'b0100;
        wait_gnts(1, 10, "single_gnt");
        wait_dones(1, 200, "single_done");
        repeat (3) step();
        if (gnt_idx_q.size() == 1 && ten_cyc_q.size() == 1 && done_idx_q.size() == 1) begin
            t = ten_cyc_q[0];
            check_int("single_gnt_idx", gnt_idx_q[0], 2);
            check_int("single_tx_en_latency", t - gnt_cyc_q[0], 1);
            check_int("single_tx_byte", int'(ten_byte_q[0]), 'hA5);
            for (int b = 0; b < 8; b++) begin
                checks++;
                if (line_log[t + 1 + 10 * (b + 1) + 5] !== exp_bits[b]) begin
                    failures++;
                    $display("FAIL single_serial_bit%0d: got=%b required=%b", b,
                             line_log[t + 1 + 10 * (b + 1) + 5], exp_bits[b]);
                end
            end
            check_int("single_done_idx", done_idx_q[0], 2);
            check_int("single_done_latency", done_cyc_q[0] - t, 101);
        end else begin
            checks++;
            failures++;
            $display("FAIL single_counts: gnt=%0d tx_en=%0d done=%0d required=1/1/1",
                     gnt_idx_q.size(), ten_cyc_q.size(), done_idx_q.size());
        end
        checks++;
        if (last_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_return_idle: busy=%b required=0", last_busy);
        end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        clear_logs();
        auto_drop = 1'b0;
        req = 4'b1111;
        wait_gnts(5, 700, "rr_gnts");
        req = '0;
        auto_drop = 1'b1;
        wait_dones(5, 300, "rr_dones");
        if (gnt_idx_q.size() == 5 && done_idx_q.size() == 5 && ten_byte_q.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check_int($sformatf("rr_gnt_order%0d", k), gnt_idx_q[k], k % 4);
                check_int($sformatf("rr_done_order%0d", k), done_idx_q[k], k % 4);
                check_int($sformatf("rr_byte%0d", k), int'(ten_byte_q[k]), int'(exp_byte[k % 4]));
            end
            for (int k = 0; k < 4; k++) begin
                check_int($sformatf("rr_spacing%0d", k), gnt_cyc_q[k + 1] - gnt_cyc_q[k], 104);
            end
        end else begin
            checks++;
            failures++;
            $display("FAIL rr_counts: gnt=%0d done=%0d required=5/5", gnt_idx_q.size(), done_idx_q.size());
        end
    endtask

    task automatic test_late_arrival();
        clear_logs();
        req = 4'b0010;
        wait_gnts(1, 10, "late_first_gnt");
        repeat (30) step();
        req = req | 4'b1001;
        wait_dones(3, 500, "late_dones");
        if (gnt_idx_q.size() == 3 && done_idx_q.size() == 3) begin
            check_int("late_gnt0", gnt_idx_q[0], 1);
            check_int("late_gnt1", gnt_idx_q[1], 3);
            check_int("late_gnt2", gnt_idx_q[2], 0);
            check_int("late_done1", done_idx_q[1], 3);
            checks++;
            if (gnt_cyc_q[1] - done_cyc_q[0] < 2) begin
                failures++;
                $display("FAIL late_gap: done1->gnt3=%0d required>=2", gnt_cyc_q[1] - done_cyc_q[0]);
            end
            checks++;
            if (gnt_cyc_q[1] - gnt_cyc_q[0] < 104) begin
                failures++;
                $display("FAIL late_rate: gnt spacing=%0d required>=104", gnt_cyc_q[1] - gnt_cyc_q[0]);
            end
        end else begin
            checks++;
            failures++;
            $display("FAIL late_counts: gnt=%0d done=%0d required=3/3", gnt_idx_q.size(), done_idx_q.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        req = 4'b0100;
        wait_gnts(1, 10, "rmid_gnt");
        repeat (50) step();
        req = 4'b1010;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (last_out !== '0) begin
            failures++;
            $display("FAIL rmid_outputs: got=%h required=0", last_out);
        end
        rst = 1'b0;
        check_int("rmid_no_done", done_idx_q.size(), 0);
        wait_gnts(2, 10, "rmid_regrant");
        if (gnt_idx_q.size() >= 2) check_int("rmid_lowest", gnt_idx_q[1], 1);
        wait_dones(2, 400, "rmid_dones");
        if (done_idx_q.size() == 2) begin
            check_int("rmid_done0", done_idx_q[0], 1);
            check_int("rmid_done1", done_idx_q[1], 3);
        end
    endtask

    task automatic test_drop();
        clear_logs();
        req = 4'b0001;
        wait_gnts(1, 10, "drop_gnt");
        repeat (20) step();
        req = req | 4'b0100;
        repeat (20) step();
        req = req & ~4'b0100;
        wait_dones(1, 200, "drop_done");
        repeat (10) step();
        check_int("drop_gnt_count", gnt_idx_q.size(), 1);
        if (gnt_idx_q.size() >= 1) check_int("drop_gnt_idx", gnt_idx_q[0], 0);
    endtask

    task automatic test_watchdog();
        clear_logs();
        force_idle = 1'b1;
        req = 4'b1000;
        wait_gnts(1, 10, "wd_gnt");
        repeat (40) step();
        check_int("wd_no_done", done_idx_q.size(), 0);
`ifdef UART_TX_ARB_WATCHDOG_EN
        check_int("wd_err_count", err_cyc_q.size(), 1);
        if (err_cyc_q.size() == 1 && ten_cyc_q.size() == 1)
            check_int("wd_err_latency", err_cyc_q[0] - ten_cyc_q[0], 20);
        checks++;
        if (last_busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_return_idle: busy=%b required=0", last_busy);
        end
`else
        check_int("wd_err_tied", err_cyc_q.size(), 0);
        checks++;
        if (last_busy !== 1'b1) begin
            failures++;
            $display("FAIL wd_wait_forever: busy=%b required=1", last_busy);
        end
`endif
        force_idle = 1'b0;
        pulse_reset();
    endtask

    task automatic test_protocol();
        check_int("proto_onehot", bad_onehot, 0);
        check_int("proto_gnt_done_same", gnt_done_same, 0);
    endtask

    initial begin
        rst         = 1'b1;
        req         = '0;
        req_byte    = {exp_byte[3], exp_byte[2], exp_byte[1], exp_byte[0]};
        inject_cplt = 1'b0;
        force_idle  = 1'b0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_late_arrival();
        test_reset_mid();
        test_drop();
        test_watchdog();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
